alu_seq: RTL and testbench

Parametrised, multi-cycle ALU for the pipelined core's execute stage. It generalises the combinational add/nand/eq ALU in three ways:
- an 8-operation set;
- registered flags;
- iterative shift and multiply behind a valid/ready handshake.

Single-cycle operations finish one cycle after accept. Shifts and multiply stall the issuing stage through `o_ready`.

---
 rtl/alu_seq.sv | 202 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle execute ALU. It runs add/nand/sub/passb in one cycle.
// Shifts step one bit per cycle and multiply is shift-add, one multiplier bit per cycle.
// Ports: i_clk, i_rst (sync high), i_valid/o_ready request handshake,
// i_op/i_ina/i_inb operands, o_valid/i_ready result handshake,
// o_out result, o_eq/o_zero/o_carry/o_ovf flags held with o_out.
module alu_seq #(
  parameter int p_WORD_LEN = 16,
  parameter bit p_MUL_EN   = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [2:0]            i_op,
  input  logic [p_WORD_LEN-1:0] i_ina,
  input  logic [p_WORD_LEN-1:0] i_inb,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [p_WORD_LEN-1:0] o_out,
  output logic                  o_eq,
  output logic                  o_zero,
  output logic                  o_carry,
  output logic                  o_ovf
);
  localparam int W  = p_WORD_LEN;
  localparam int LW = $clog2(W);
  localparam int CW = LW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_NAND  = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_SHL   = 3'd3;
  localparam logic [2:0] OP_SHR   = 3'd4;
  localparam logic [2:0] OP_SRA   = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;
  localparam logic [2:0] OP_PASSB = 3'd7;

  logic [1:0]    state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          eq_q, eq_d;
  logic          zero_q, zero_d;
  logic          carry_q, carry_d;
  logic          ovf_q, ovf_d;

  logic [W:0]    add_s, sub_s, mul_s;
  logic [LW-1:0] amt;
  logic [W-1:0]  shl_v, shr_v, sra_v;
  logic [W-1:0]  res;
  logic          res_c, res_v, fin;

  assign add_s = {1'b0, i_ina} + {1'b0, i_inb};
  assign sub_s = {1'b0, i_ina} + {1'b0, ~i_inb}
               + {{W{1'b0}}, 1'b1};
  assign amt   = i_inb[LW-1:0];

  assign shl_v = {a_q[W-2:0], 1'b0};
  assign shr_v = {1'b0, a_q[W-1:1]};
  assign sra_v = {a_q[W-1], a_q[W-1:1]};

  // {hi,b} is the product register; b shifts out
  // multiplier bits as product bits shift in.
  assign mul_s = {1'b0, hi_q}
               + (b_q[0] ? {1'b0, a_q} : '0);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    eq_d    = eq_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          op_d = i_op;
          a_d  = i_ina;
          b_d  = i_inb;
          hi_d = '0;
          eq_d = (i_ina == i_inb);
          fin  = 1'b1;
          case (i_op)
            OP_ADD: begin
              res   = add_s[W-1:0];
              res_c = add_s[W];
              res_v = (i_ina[W-1] == i_inb[W-1])
                    && (add_s[W-1] != i_ina[W-1]);
            end
            OP_NAND: res = ~(i_ina & i_inb);
            OP_SUB: begin
              res   = sub_s[W-1:0];
              res_c = sub_s[W];
              res_v = (i_ina[W-1] != i_inb[W-1])
                    && (sub_s[W-1] != i_ina[W-1]);
            end
            OP_SHL, OP_SHR, OP_SRA: begin
              if (amt == '0) begin
                res = i_ina;
              end else begin
                fin     = 1'b0;
                cnt_d   = CW'(amt);
                state_d = S_BUSY;
              end
            end
            OP_MUL: begin
              if (p_MUL_EN) begin
                fin     = 1'b0;
                cnt_d   = CW'(W);
                state_d = S_BUSY;
              end
            end
            OP_PASSB: res = i_inb;
            default: res = '0;
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        case (op_q)
          OP_SHL: a_d = shl_v;
          OP_SHR: a_d = shr_v;
          OP_SRA: a_d = sra_v;
          OP_MUL: begin
            hi_d = mul_s[W:1];
            b_d  = {mul_s[0], b_q[W-1:1]};
          end
          default: a_d = a_q;
        endcase
        if (cnt_q == CW'(1)) begin
          fin   = 1'b1;
          res   = (op_q == OP_MUL) ? b_d : a_d;
          res_v = (op_q == OP_MUL) && (hi_d != '0);
        end
      end
      S_DONE: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      state_d = S_DONE;
      out_d   = res;
      zero_d  = (res == '0);
      carry_d = res_c;
      ovf_d   = res_v;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      eq_q    <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      eq_q    <= eq_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign o_out   = out_q;
  assign o_eq    = eq_q;
  assign o_zero  = zero_q;
  assign o_carry = carry_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: random and directed stimulus for alu_seq.
// The transaction-level reference model is checked every cycle.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b1;
  logic [2:0]   i_op = 3'd0;
  logic [W-1:0] ina = '0;
  logic [W-1:0] inb = '0;
  logic         o_ready, o_valid;
  logic [W-1:0] o_out;
  logic         o_eq, o_zero, o_carry, o_ovf;

  int total = 0;
  int bad = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  alu_seq #(.p_WORD_LEN(W), .p_MUL_EN(1'b1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_ina(ina), .i_inb(inb),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_out(o_out), .o_eq(o_eq), .o_zero(o_zero),
    .o_carry(o_carry), .o_ovf(o_ovf)
  );

  typedef struct packed {
    logic [15:0] out;
    logic        eq;
    logic        zero;
    logic        carry;
    logic        ovf;
    logic [7:0]  lat;
  } res_t;

  function automatic res_t ref_model(input logic [2:0] op,
                                     input logic [15:0] a,
                                     input logic [15:0] b);
    res_t r;
    int s;
    int n;
    logic [31:0] p;
    r = '0;
    n = int'(b[3:0]);
    r.lat = 8'd1;
    r.eq = (a == b);
    case (op)
      3'd0: begin
        s = int'(a) + int'(b);
        r.out = 16'(s);
        r.carry = (s > 65535);
        s = int'($signed(a)) + int'($signed(b));
        r.ovf = (s > 32767) || (s < -32768);
      end
      3'd1: r.out = ~(a & b);
      3'd2: begin
        r.out = 16'(int'(a) - int'(b));
        r.carry = (a >= b);
        s = int'($signed(a)) - int'($signed(b));
        r.ovf = (s > 32767) || (s < -32768);
      end
      3'd3: begin r.out = a << n; r.lat = 8'(n + 1); end
      3'd4: begin r.out = a >> n; r.lat = 8'(n + 1); end
      3'd5: begin
        r.out = 16'($signed(a) >>> n);
        r.lat = 8'(n + 1);
      end
      3'd6: begin
        p = 32'(a) * 32'(b);
        r.out = p[15:0];
        r.ovf = (p[31:16] != 16'd0);
        r.lat = 8'd17;
      end
      default: r.out = b;
    endcase
    r.zero = (r.out == 16'd0);
    return r;
  endfunction

  res_t nxt;
  assign nxt = ref_model(i_op, ina, inb);

  logic       m_pend = 1'b0;
  logic [7:0] m_left = 8'd0;
  res_t       m_res = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_pend <= 1'b0;
      m_left <= 8'd0;
    end else if (m_pend) begin
      if (m_left != 8'd0) m_left <= m_left - 8'd1;
      else if (i_ready) m_pend <= 1'b0;
    end else if (i_valid) begin
      m_res  <= nxt;
      m_left <= nxt.lat - 8'd1;
      m_pend <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("ready", 32'(o_ready), 32'(!m_pend));
      chk("valid", 32'(o_valid), 32'(m_pend && m_left == 8'd0));
      if (o_valid && m_pend && m_left == 8'd0) begin
        chk("out", 32'(o_out), 32'(m_res.out));
        chk("flags", 32'({o_eq, o_zero, o_carry, o_ovf}),
            32'({m_res.eq, m_res.zero, m_res.carry, m_res.ovf}));
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!o_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) chk("ready_timeout", 32'(o_ready), 32'd1);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] eo,
                       input logic [3:0] ef, input int el,
                       input bit pulse);
    int lat;
    i_ready = 1'b1;
    wait_ready();
    i_op = op; ina = a; inb = b; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 40) begin
      if (pulse && lat == 3) begin
        i_valid = 1'b1; i_op = 3'd0;
        ina = 16'h0005; inb = 16'h0006;
      end else begin
        i_valid = 1'b0;
      end
      if (pulse) chk("busy_ready", 32'(o_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    i_valid = 1'b0;
    chk("lat_valid", 32'(o_valid), 32'd1);
    chk("lat", 32'(lat), 32'(el));
    chk("d_out", 32'(o_out), 32'(eo));
    chk("d_flags", 32'({o_eq, o_zero, o_carry, o_ovf}), 32'(ef));
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    started = 1'b1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_out", 32'(o_out), 32'd0);
    chk("rst_flags", 32'({o_eq, o_zero, o_carry, o_ovf}), 32'd0);

    // flags are {eq, zero, carry, ovf}
    do_op(3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1, 1'b0);
    @(negedge clk);
    chk("add_ready_back", 32'(o_ready), 32'd1);
    do_op(3'd1, 16'hF0F0, 16'hFF00, 16'h0FFF, 4'b0000, 1, 1'b0);
    do_op(3'd2, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 1, 1'b0);
    do_op(3'd2, 16'h1234, 16'h1234, 16'h0000, 4'b1110, 1, 1'b0);
    do_op(3'd5, 16'h8000, 16'h0014, 16'hF800, 4'b0000, 5, 1'b0);
    do_op(3'd3, 16'h0001, 16'h0000, 16'h0001, 4'b0000, 1, 1'b0);
    do_op(3'd6, 16'h0100, 16'h0101, 16'h0100, 4'b0001, 17, 1'b1);
    do_op(3'd7, 16'h1111, 16'hABCD, 16'hABCD, 4'b0000, 1, 1'b0);

    // backpressure: result held while the consumer stalls
    wait_ready();
    i_ready = 1'b0;
    i_op = 3'd0; ina = 16'd3; inb = 16'd4; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      chk("bp_valid", 32'(o_valid), 32'd1);
      chk("bp_out", 32'(o_out), 32'h7);
      if (v == 4) i_ready = 1'b1;
      @(negedge clk);
    end
    chk("bp_released", 32'(o_valid), 32'd0);
    chk("bp_idle", 32'(o_ready), 32'd1);

    // reset on the 8th busy cycle of a multiply
    wait_ready();
    i_op = 3'd6; ina = 16'h0123; inb = 16'h0456; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy", 32'(o_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", 32'(o_valid), 32'd0);
    chk("abort_out", 32'(o_out), 32'd0);
    chk("abort_ready", 32'(o_ready), 32'd1);
    do_op(3'd0, 16'd1, 16'd1, 16'h0002, 4'b1000, 1, 1'b0);

    // randomized traffic, checked by the compare process
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      i_valid = ($urandom_range(0, 1) == 1);
      i_op = 3'($urandom_range(0, 7));
      ina = 16'($urandom);
      case ($urandom_range(0, 3))
        0: inb = ina;
        1: inb = 16'($urandom_range(0, 20));
        default: inb = 16'($urandom);
      endcase
      i_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (30) @(negedge clk);
    chk("final_idle", 32'(o_ready), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
